// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iterative
// Purpose  : Multi-cycle RV32M multiply/divide unit. Shift-add multiply and
//            restoring divide, one bit per cycle over a 2*XLEN accumulator.
//            Divide-by-zero and signed-overflow cases take a one-cycle path.
//            Valid/ready handshake on both sides; a tag rides along with
//            each request so writeback knows the destination register.
// Options  : `define MDU_FAST_MUL_EN -> multiplies use a single-cycle
//            product (latency 1); results are identical, only latency moves.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] TAG_IN,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  RESULT,
    output logic             ZERO,
    output logic [TAG_W-1:0] TAG_OUT
);

    localparam int               CNT_W     = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  SMIN      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    b_mag_q;
    logic [2*XLEN-1:0]  acc_q;
    logic               prod_neg_q;
    logic               rem_neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    result_q;
    logic               zero_q;
    logic [TAG_W-1:0]   tag_q;
    logic               out_valid_q;

    // Accept-side decode
    logic               a_signed, b_signed;
    logic               a_neg_d, b_neg_d;
    logic [XLEN-1:0]    a_mag_d, b_mag_d;
    logic               div_zero, div_ovf;
    logic               fast_d;
    logic [XLEN-1:0]    fast_res_d;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0]  prod_full;
`endif

    // Iteration datapath
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      rem_sh;
    logic               rem_ge;
    logic [XLEN-1:0]    rem_diff;
    logic [2*XLEN-1:0]  acc_d;
    logic [2*XLEN-1:0]  prod_signed;
    logic [XLEN-1:0]    quo_signed;
    logic [XLEN-1:0]    rem_signed;
    logic [XLEN-1:0]    res_d;

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign TAG_OUT   = tag_q;

    // Convert incoming operands to magnitudes and spot divide corner cases.
    always_comb begin
        a_signed   = (OP == OP_MULH) || (OP == OP_MULHSU) || (OP == OP_DIV) || (OP == OP_REM);
        b_signed   = (OP == OP_MULH) || (OP == OP_DIV) || (OP == OP_REM);
        a_neg_d    = a_signed & DATA1[XLEN-1];
        b_neg_d    = b_signed & DATA2[XLEN-1];
        a_mag_d    = a_neg_d ? -DATA1 : DATA1;
        b_mag_d    = b_neg_d ? -DATA2 : DATA2;
        div_zero   = OP[2] && (DATA2 == '0);
        // Only signed DIV/REM (OP[0]==0) can overflow.
        div_ovf    = OP[2] && !OP[0] && (DATA1 == SMIN) && (DATA2 == '1);
        fast_d     = div_zero || div_ovf;
        fast_res_d = '0;
        if (div_zero) begin
            fast_res_d = OP[1] ? DATA1 : '1;
        end else if (div_ovf) begin
            fast_res_d = OP[1] ? '0 : DATA1;
        end
`ifdef MDU_FAST_MUL_EN
        prod_full = {{XLEN{1'b0}}, a_mag_d} * {{XLEN{1'b0}}, b_mag_d};
        if (a_neg_d ^ b_neg_d) begin
            prod_full = -prod_full;
        end
        if (!OP[2]) begin
            fast_d     = 1'b1;
            fast_res_d = (OP == OP_MUL) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];
        end
`endif
    end

    // One multiply or divide step, plus sign correction of the step's output.
    always_comb begin
        // Multiply: low half holds the multiplier, add multiplicand into the
        // high half when the current multiplier bit is set, then shift right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        // Divide: high half is the partial remainder, low half shifts the
        // dividend out and the quotient in.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_ge   = (rem_sh >= {1'b0, b_mag_q});
        rem_diff = rem_sh[XLEN-1:0] - b_mag_q;
        if (op_q[2]) begin
            acc_d = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_signed = prod_neg_q ? -acc_d : acc_d;
        quo_signed  = prod_neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem_signed  = rem_neg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      res_d = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             res_d = quo_signed;
            default:                     res_d = rem_signed;
        endcase
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            b_mag_q     <= '0;
            acc_q       <= '0;
            prod_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (FLUSH) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID) begin
                        op_q       <= OP;
                        b_mag_q    <= b_mag_d;
                        prod_neg_q <= a_neg_d ^ b_neg_d;
                        rem_neg_q  <= a_neg_d;
                        tag_q      <= TAG_IN;
                        cnt_q      <= '0;
                        // Fast-path results wait in the accumulator for
                        // one cycle before being presented.
                        acc_q      <= {{XLEN{1'b0}}, (fast_d ? fast_res_d : a_mag_d)};
                        state_q    <= fast_d ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        result_q    <= res_d;
                        zero_q      <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        result_q    <= acc_q[XLEN-1:0];
                        zero_q      <= (acc_q[XLEN-1:0] == '0);
                        out_valid_q <= 1'b1;
                    end else if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iterative
// Purpose  : Directed self-checking bench for mdu_iterative (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT  = 32;
    localparam int FAST_LAT = 1;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [2:0]  OP = 3'b000;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [4:0]  TAG_IN = '0;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] RESULT;
    logic        ZERO;
    logic [4:0]  TAG_OUT;

    int pass_cnt = 0;
    int total_cnt = 0;

    mdu_iterative #(.XLEN(32), .TAG_W(5)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .OP       (OP),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .TAG_IN   (TAG_IN),
        .FLUSH    (FLUSH),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .RESULT   (RESULT),
        .ZERO     (ZERO),
        .TAG_OUT  (TAG_OUT)
    );

    always #5 CLK = ~CLK;

    // Wait (bounded) for IN_READY, present one request, accept on next edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        for (int k = 0; k < 100; k++) begin
            if (IN_READY) break;
            @(posedge CLK); #1;
        end
        OP = op; DATA1 = a; DATA2 = b; TAG_IN = tag; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        // Scramble inputs: the unit must ignore them after accept.
        OP = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom; TAG_IN = 5'($urandom);
    endtask

    // Count edges after accept until OUT_VALID; -1 when the bound expires.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drain();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res, output logic zero,
                          output logic [4:0] tago, output int lat);
        issue(op, a, b, tag);
        wait_valid(lat);
        res = RESULT; zero = ZERO; tago = TAG_OUT;
        drain();
    endtask

    task automatic test_reset();
        total_cnt++; if (IN_READY !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", IN_READY); else pass_cnt++;
        total_cnt++; if (OUT_VALID !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", OUT_VALID); else pass_cnt++;
        total_cnt++; if (RESULT !== 32'h0) $display("FAIL rst_result got %h exp 00000000", RESULT); else pass_cnt++;
        total_cnt++; if (ZERO !== 1'b1) $display("FAIL rst_zero got %b exp 1", ZERO); else pass_cnt++;
        total_cnt++; if (TAG_OUT !== 5'd0) $display("FAIL rst_tag got %0d exp 0", TAG_OUT); else pass_cnt++;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z; logic [4:0] t; int lat;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFEB) $display("FAIL mul_res got %h exp FFFFFFEB", r); else pass_cnt++;
        total_cnt++; if (z !== 1'b0) $display("FAIL mul_zero got %b exp 0", z); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mul_lat got %0d exp %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (t !== 5'd3) $display("FAIL mul_tag got %0d exp 3", t); else pass_cnt++;
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd4, r, z, t, lat);
        total_cnt++; if (r !== 32'h40000000) $display("FAIL mulh_res got %h exp 40000000", r); else pass_cnt++;
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu_res got %h exp FFFFFFFF", r); else pass_cnt++;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_res got %h exp FFFFFFFE", r); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mulhu_lat got %0d exp %0d", lat, MUL_LAT); else pass_cnt++;
        // Small high half is zero: exercises ZERO=1 on a multiply.
        run_op(3'b011, 32'd3, 32'd5, 5'd7, r, z, t, lat);
        total_cnt++; if (r !== 32'h0 || z !== 1'b1) $display("FAIL mulhu_small got %h/%b exp 00000000/1", r, z); else pass_cnt++;
    endtask

    task automatic test_div();
        logic [31:0] r; logic z; logic [4:0] t; int lat;
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd8, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFFD) $display("FAIL div_res got %h exp FFFFFFFD", r); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL div_lat got %0d exp %0d", lat, DIV_LAT); else pass_cnt++;
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd9, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL rem_res got %h exp FFFFFFFF", r); else pass_cnt++;
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 5'd10, r, z, t, lat);
        total_cnt++; if (r !== 32'h7FFFFFFC) $display("FAIL divu_res got %h exp 7FFFFFFC", r); else pass_cnt++;
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, 5'd11, r, z, t, lat);
        total_cnt++; if (r !== 32'h1) $display("FAIL remu_res got %h exp 00000001", r); else pass_cnt++;
        // Negative divisor: 100 / -7 = -14 rem 2.
        run_op(3'b100, 32'd100, 32'hFFFFFFF9, 5'd12, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFF2) $display("FAIL div_negb got %h exp FFFFFFF2", r); else pass_cnt++;
        run_op(3'b110, 32'd100, 32'hFFFFFFF9, 5'd13, r, z, t, lat);
        total_cnt++; if (r !== 32'h2) $display("FAIL rem_negb got %h exp 00000002", r); else pass_cnt++;
    endtask

    task automatic test_fast_path();
        logic [31:0] r; logic z; logic [4:0] t; int lat;
        run_op(3'b101, 32'd5, 32'd0, 5'd1, r, z, t, lat);
        total_cnt++; if (r !== 32'hFFFFFFFF) $display("FAIL divu0_res got %h exp FFFFFFFF", r); else pass_cnt++;
        total_cnt++; if (lat !== FAST_LAT) $display("FAIL divu0_lat got %0d exp 1", lat); else pass_cnt++;
        run_op(3'b110, 32'd5, 32'd0, 5'd2, r, z, t, lat);
        total_cnt++; if (r !== 32'd5) $display("FAIL rem0_res got %h exp 00000005", r); else pass_cnt++;
        total_cnt++; if (lat !== FAST_LAT) $display("FAIL rem0_lat got %0d exp 1", lat); else pass_cnt++;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, r, z, t, lat);
        total_cnt++; if (r !== 32'h80000000) $display("FAIL divovf_res got %h exp 80000000", r); else pass_cnt++;
        total_cnt++; if (lat !== FAST_LAT) $display("FAIL divovf_lat got %0d exp 1", lat); else pass_cnt++;
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, r, z, t, lat);
        total_cnt++; if (r !== 32'h0 || z !== 1'b1) $display("FAIL removf got %h/%b exp 00000000/1", r, z); else pass_cnt++;
        total_cnt++; if (lat !== FAST_LAT) $display("FAIL removf_lat got %0d exp 1", lat); else pass_cnt++;
        total_cnt++; if (t !== 5'd15) $display("FAIL removf_tag got %0d exp 15", t); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lat; bit bad;
        issue(3'b101, 32'd100, 32'd7, 5'd17);
        wait_valid(lat);
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL bp_lat got %0d exp %0d", lat, DIV_LAT); else pass_cnt++;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (RESULT !== 32'd14 || TAG_OUT !== 5'd17 || IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin
                if (!bad) $display("FAIL bp_hold got res=%h tag=%0d rdy=%b vld=%b exp 0000000e/17/0/1",
                                   RESULT, TAG_OUT, IN_READY, OUT_VALID);
                bad = 1'b1;
            end
            @(posedge CLK); #1;
        end
        total_cnt++; if (!bad) pass_cnt++;
        drain();
        total_cnt++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) $display("FAIL bp_release got rdy=%b vld=%b exp 1/0", IN_READY, OUT_VALID); else pass_cnt++;
    endtask

    task automatic test_flush();
        bit seen;
        issue(3'b100, 32'd1000, 32'hFFFFFFFD, 5'd20);
        repeat (9) begin @(posedge CLK); #1; end
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        total_cnt++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) $display("FAIL flush_idle got rdy=%b vld=%b exp 1/0", IN_READY, OUT_VALID); else pass_cnt++;
        total_cnt++; if (RESULT !== 32'd14) $display("FAIL flush_keep got %h exp 0000000e", RESULT); else pass_cnt++;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL flush_no_out got valid=1 exp 0"); else pass_cnt++;
        // FLUSH alongside a request in IDLE blocks the accept.
        OP = 3'b000; DATA1 = 32'd2; DATA2 = 32'd3; IN_VALID = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; FLUSH = 1'b0;
        total_cnt++; if (IN_READY !== 1'b1) $display("FAIL flush_block got rdy=%b exp 1", IN_READY); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [31:0] r; logic z; logic [4:0] t; int lat;
        issue(3'b100, 32'd1000, 32'd3, 5'd22);
        repeat (5) @(posedge CLK);
        #3 RESET_N = 1'b0;
        #1;
        total_cnt++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || RESULT !== 32'h0 || ZERO !== 1'b1 || TAG_OUT !== 5'd0)
            $display("FAIL async_rst got rdy=%b vld=%b res=%h z=%b tag=%0d exp 1/0/00000000/1/0",
                     IN_READY, OUT_VALID, RESULT, ZERO, TAG_OUT);
        else pass_cnt++;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (OUT_VALID) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL rst_no_out got valid=1 exp 0"); else pass_cnt++;
        run_op(3'b000, 32'd6, 32'd7, 5'd23, r, z, t, lat);
        total_cnt++; if (r !== 32'd42 || t !== 5'd23) $display("FAIL post_rst got %h/%0d exp 0000002a/23", r, t); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic z; logic [4:0] t; int lat;
        run_op(3'b111, 32'd0, 32'd9, 5'd24, r, z, t, lat);
        total_cnt++; if (r !== 32'h0 || z !== 1'b1) $display("FAIL b2b_first got %h/%b exp 00000000/1", r, z); else pass_cnt++;
        total_cnt++; if (IN_READY !== 1'b1) $display("FAIL b2b_ready got %b exp 1", IN_READY); else pass_cnt++;
        run_op(3'b101, 32'd99, 32'd9, 5'd25, r, z, t, lat);
        total_cnt++; if (r !== 32'd11 || z !== 1'b0 || t !== 5'd25) $display("FAIL b2b_second got %h/%b/%0d exp 0000000b/0/25", r, z, t); else pass_cnt++;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        test_mul();
        test_div();
        test_fast_path();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
